// File: rtl/dcache_port_arbiter.sv
// Arbitrates load-pipeline and store-buffer requests onto the single data-cache port.
// One transaction at a time; flushed loads are drained silently so the cache never sees an abort.
module dcache_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [3:0]  ld_rmask_i,
  output logic        ld_gnt_o,

  input  logic        st_req_i,
  input  logic [31:0] st_addr_i,
  input  logic [3:0]  st_wmask_i,
  input  logic [31:0] st_wdata_i,
  input  logic        st_urgent_i,
  output logic        st_gnt_o,

  input  logic        flush_i,

  output logic [31:0] ufp_addr_o,
  output logic [3:0]  ufp_rmask_o,
  output logic [3:0]  ufp_wmask_o,
  output logic [31:0] ufp_wdata_o,
  input  logic [31:0] ufp_rdata_i,
  input  logic        ufp_resp_i,

  output logic        ld_resp_o,
  output logic [31:0] ld_rdata_o,
  output logic        st_done_o,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic idle_ok;
  logic st_win;
  logic ld_win;
  logic unused_addr_bits;

  // Byte offset never reaches the cache; the masks carry lane selection.
  assign unused_addr_bits = ^{ld_addr_i[1:0], st_addr_i[1:0]};

  // Grants are gated by rst so nothing is accepted while reset is applied.
  assign idle_ok = (state_q == IDLE) && !rst;
  assign st_win  = idle_ok && st_req_i &&
                   (st_urgent_i || (starve_cnt_q == LIMIT) || !ld_req_i);
  assign ld_win  = idle_ok && ld_req_i && !flush_i && !st_win;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (st_win)      state_d = STORE;
        else if (ld_win) state_d = LOAD;
      end
      LOAD: begin
        if (ufp_resp_i)   state_d = IDLE;
        else if (flush_i) state_d = DRAIN;
      end
      STORE: begin
        if (ufp_resp_i) state_d = IDLE;
      end
      DRAIN: begin
        if (ufp_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (st_win) begin
      req_d.word_addr = st_addr_i[31:2];
      req_d.rmask     = 4'b0000;
      req_d.wmask     = st_wmask_i;
      req_d.wdata     = st_wdata_i;
    end else if (ld_win) begin
      req_d.word_addr = ld_addr_i[31:2];
      req_d.rmask     = ld_rmask_i;
      req_d.wmask     = 4'b0000;
      req_d.wdata     = 32'h0;
    end
  end

  // Counts loads that jumped a waiting store; any store grant or idle store side resets it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (st_win || !st_req_i) begin
      starve_cnt_d = '0;
    end else if (ld_win && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    ld_gnt_o    = ld_win;
    st_gnt_o    = st_win;
    ufp_addr_o  = 32'h0;
    ufp_rmask_o = 4'b0000;
    ufp_wmask_o = 4'b0000;
    ufp_wdata_o = 32'h0;
    ld_resp_o   = 1'b0;
    ld_rdata_o  = 32'h0;
    st_done_o   = 1'b0;
    busy_o      = 1'b0;

    if (!rst && (state_q != IDLE)) begin
      busy_o      = 1'b1;
      ufp_addr_o  = {req_q.word_addr, 2'b00};
      ufp_rmask_o = req_q.rmask;
      ufp_wmask_o = req_q.wmask;
      ufp_wdata_o = req_q.wdata;
    end

    if (!rst && (state_q == LOAD) && ufp_resp_i && !flush_i) begin
      ld_resp_o  = 1'b1;
      ld_rdata_o = ufp_rdata_i;
    end

    if (!rst && (state_q == STORE) && ufp_resp_i) begin
      st_done_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: inputs change 1 time unit after the
// rising edge and outputs are sampled on the falling edge.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_rmask = '0;
  logic        ld_gnt;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [3:0]  st_wmask = '0;
  logic [31:0] st_wdata = '0;
  logic        st_urgent = 1'b0;
  logic        st_gnt;
  logic        flush = 1'b0;
  logic [31:0] ufp_addr;
  logic [3:0]  ufp_rmask;
  logic [3:0]  ufp_wmask;
  logic [31:0] ufp_wdata;
  logic [31:0] ufp_rdata = '0;
  logic        ufp_resp = 1'b0;
  logic        ld_resp;
  logic [31:0] ld_rdata;
  logic        st_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dcache_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_req_i    (ld_req),
    .ld_addr_i   (ld_addr),
    .ld_rmask_i  (ld_rmask),
    .ld_gnt_o    (ld_gnt),
    .st_req_i    (st_req),
    .st_addr_i   (st_addr),
    .st_wmask_i  (st_wmask),
    .st_wdata_i  (st_wdata),
    .st_urgent_i (st_urgent),
    .st_gnt_o    (st_gnt),
    .flush_i     (flush),
    .ufp_addr_o  (ufp_addr),
    .ufp_rmask_o (ufp_rmask),
    .ufp_wmask_o (ufp_wmask),
    .ufp_wdata_o (ufp_wdata),
    .ufp_rdata_i (ufp_rdata),
    .ufp_resp_i  (ufp_resp),
    .ld_resp_o   (ld_resp),
    .ld_rdata_o  (ld_rdata),
    .st_done_o   (st_done),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_req = 1'b1; st_req = 1'b1; ufp_resp = 1'b1; ld_addr = 32'h10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({ld_gnt, st_gnt, ld_resp, st_done, busy} !== 5'b0) begin
        errors++; $display("FAIL reset_ctrl got %b want 00000", {ld_gnt, st_gnt, ld_resp, st_done, busy});
      end
      checks++;
      if ({ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, ld_rdata} !== 104'h0) begin
        errors++; $display("FAIL reset_data got addr %h rm %h wm %h wd %h rd %h want 0",
                           ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, ld_rdata);
      end
      tick();
    end
    rst = 1'b0; ld_req = 1'b0; st_req = 1'b0; ufp_resp = 1'b0; ld_addr = '0;
    tick();
  endtask

  task automatic test_load_basic();
    ld_req = 1'b1; ld_addr = 32'h1003; ld_rmask = 4'b1000;
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt} !== 2'b10) begin
      errors++; $display("FAIL load_grant got %b want 10", {ld_gnt, st_gnt});
    end
    tick();
    ld_req = 1'b0; ld_addr = '0; ld_rmask = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ufp_addr, ufp_rmask, ufp_wmask} !== {32'h1000, 4'b1000, 4'b0000}) begin
        errors++; $display("FAIL load_hold cyc %0d got %h %b %b want 00001000 1000 0000", i, ufp_addr, ufp_rmask, ufp_wmask);
      end
      checks++;
      if ({ld_resp, busy} !== 2'b01) begin
        errors++; $display("FAIL load_wait cyc %0d got resp/busy %b want 01", i, {ld_resp, busy});
      end
      tick();
    end
    ufp_resp = 1'b1; ufp_rdata = 32'hAABBCCDD;
    @(negedge clk);
    checks++;
    if ({ld_resp, ld_rdata, ufp_addr} !== {1'b1, 32'hAABBCCDD, 32'h1000}) begin
      errors++; $display("FAIL load_resp got %b %h addr %h want 1 aabbccdd 00001000", ld_resp, ld_rdata, ufp_addr);
    end
    tick();
    ufp_resp = 1'b0; ufp_rdata = '0;
    @(negedge clk);
    checks++;
    if ({busy, ld_resp, ufp_addr, ufp_rmask} !== 38'h0) begin
      errors++; $display("FAIL load_idle got busy %b resp %b addr %h rm %b want all 0", busy, ld_resp, ufp_addr, ufp_rmask);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic exp_st;
    ld_req = 1'b1; ld_addr = 32'h40; ld_rmask = 4'hF;
    st_req = 1'b1; st_addr = 32'h2002; st_wmask = 4'b0011; st_wdata = 32'h12345678;
    for (int g = 0; g < 18; g++) begin
      exp_st = ((g % 9) == 8);
      ufp_resp = 1'b0;
      @(negedge clk);
      checks++;
      if ({ld_gnt, st_gnt} !== (exp_st ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL starve_grant g %0d got %b want %b", g, {ld_gnt, st_gnt}, exp_st ? 2'b01 : 2'b10);
      end
      tick();
      ufp_resp = 1'b1; ufp_rdata = 32'(g) + 32'h100;
      @(negedge clk);
      checks++;
      if (exp_st) begin
        if ({ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, st_done, ld_resp} !==
            {32'h2000, 4'b0000, 4'b0011, 32'h12345678, 1'b1, 1'b0}) begin
          errors++; $display("FAIL starve_store g %0d got %h %b %b %h done %b lresp %b want 00002000 0000 0011 12345678 1 0",
                             g, ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, st_done, ld_resp);
        end
      end else begin
        if ({ufp_addr, ufp_wmask, ld_resp, ld_rdata, st_done} !==
            {32'h40, 4'b0000, 1'b1, 32'(g) + 32'h100, 1'b0}) begin
          errors++; $display("FAIL starve_load g %0d got %h %b resp %b %h done %b want 00000040 0000 1 %h 0",
                             g, ufp_addr, ufp_wmask, ld_resp, ld_rdata, st_done, 32'(g) + 32'h100);
        end
      end
      tick();
    end
    ld_req = 1'b0; st_req = 1'b0; ufp_resp = 1'b0; ufp_rdata = '0;
    tick();
  endtask

  task automatic test_urgent();
    ld_req = 1'b1; ld_addr = 32'h50; ld_rmask = 4'h1;
    st_req = 1'b1; st_urgent = 1'b1; st_addr = 32'h3000; st_wmask = 4'hF; st_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt} !== 2'b01) begin
      errors++; $display("FAIL urgent_grant got %b want 01", {ld_gnt, st_gnt});
    end
    tick();
    ld_req = 1'b0; st_req = 1'b0; st_urgent = 1'b0;
    @(negedge clk);
    checks++;
    if ({ufp_wdata, ufp_wmask, st_done, busy} !== {32'hCAFEF00D, 4'hF, 1'b0, 1'b1}) begin
      errors++; $display("FAIL urgent_hold got %h %b done %b busy %b want cafef00d 1111 0 1", ufp_wdata, ufp_wmask, st_done, busy);
    end
    tick();
    ufp_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({st_done, ld_resp} !== 2'b10) begin
      errors++; $display("FAIL urgent_done got %b want 10", {st_done, ld_resp});
    end
    tick();
    ufp_resp = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, st_done} !== 2'b00) begin
      errors++; $display("FAIL urgent_idle got %b want 00", {busy, st_done});
    end
    tick();
  endtask

  task automatic test_flush_load();
    ld_req = 1'b1; ld_addr = 32'h1237; ld_rmask = 4'b0010;
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt} !== 2'b10) begin
      errors++; $display("FAIL flush_grant got %b want 10", {ld_gnt, st_gnt});
    end
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({ld_resp, ld_gnt, busy} !== 3'b001) begin
      errors++; $display("FAIL flush_cycle got %b want 001", {ld_resp, ld_gnt, busy});
    end
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, ld_gnt, ld_resp, ufp_addr, ufp_rmask} !== {3'b100, 32'h1234, 4'b0010}) begin
        errors++; $display("FAIL drain_hold cyc %0d got %b %h %b want 100 00001234 0010", i, {busy, ld_gnt, ld_resp}, ufp_addr, ufp_rmask);
      end
      tick();
    end
    ld_req = 1'b0; ufp_resp = 1'b1; ufp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({ld_resp, ld_rdata} !== 33'h0) begin
      errors++; $display("FAIL drain_resp got %b %h want 0 00000000", ld_resp, ld_rdata);
    end
    tick();
    ufp_resp = 1'b0; ufp_rdata = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drain_idle got busy %b want 0", busy);
    end
    tick();
    ld_req = 1'b1; ld_addr = 32'h2000; ld_rmask = 4'hF;
    tick();
    ld_req = 1'b0; flush = 1'b1; ufp_resp = 1'b1; ufp_rdata = 32'h11111111;
    @(negedge clk);
    checks++;
    if ({ld_resp, ld_rdata} !== 33'h0) begin
      errors++; $display("FAIL flush_with_resp got %b %h want 0 00000000", ld_resp, ld_rdata);
    end
    tick();
    flush = 1'b0; ufp_resp = 1'b0; ufp_rdata = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_with_resp_idle got busy %b want 0", busy);
    end
    tick();
  endtask

  task automatic test_flush_store();
    st_req = 1'b1; st_addr = 32'h4004; st_wmask = 4'b0001; st_wdata = 32'hEF; flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt} !== 2'b01) begin
      errors++; $display("FAIL flush_idle_store got %b want 01", {ld_gnt, st_gnt});
    end
    tick();
    st_req = 1'b0; ufp_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({st_done, ufp_addr, ufp_wmask} !== {1'b1, 32'h4004, 4'b0001}) begin
      errors++; $display("FAIL flush_store_done got %b %h %b want 1 00004004 0001", st_done, ufp_addr, ufp_wmask);
    end
    tick();
    ufp_resp = 1'b0; ld_req = 1'b1; ld_addr = 32'h60; ld_rmask = 4'hF;
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt, busy} !== 3'b000) begin
      errors++; $display("FAIL flush_blocks_load got %b want 000", {ld_gnt, st_gnt, busy});
    end
    tick();
    ld_req = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_blocks_load_idle got busy %b want 0", busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ld_req = 1'b1; ld_addr = 32'h88; ld_rmask = 4'hF;
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt} !== 2'b10) begin
      errors++; $display("FAIL rstmid_grant got %b want 10", {ld_gnt, st_gnt});
    end
    tick();
    ld_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ld_resp, ld_gnt, ufp_addr, ufp_rmask} !== 39'h0) begin
      errors++; $display("FAIL rstmid_outputs got %b %h %b want 000 00000000 0000", {busy, ld_resp, ld_gnt}, ufp_addr, ufp_rmask);
    end
    tick();
    rst = 1'b0; ufp_resp = 1'b1; ufp_rdata = 32'h55555555; ld_req = 1'b1; ld_addr = 32'h90;
    @(negedge clk);
    checks++;
    if ({ld_resp, ld_rdata, busy, ld_gnt} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rstmid_late_resp got resp %b %h busy %b gnt %b want 0 00000000 0 1", ld_resp, ld_rdata, busy, ld_gnt);
    end
    tick();
    ufp_resp = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ufp_addr} !== {1'b1, 32'h90}) begin
      errors++; $display("FAIL rstmid_new_req got busy %b addr %h want 1 00000090", busy, ufp_addr);
    end
    tick();
    ufp_resp = 1'b1; ufp_rdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if ({ld_resp, ld_rdata} !== {1'b1, 32'h0BADF00D}) begin
      errors++; $display("FAIL rstmid_new_resp got %b %h want 1 0badf00d", ld_resp, ld_rdata);
    end
    tick();
    ufp_resp = 1'b0; ufp_rdata = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_starvation();
    test_urgent();
    test_flush_load();
    test_flush_store();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Single-ported arbiter and sequencer between the load pipeline and the post-commit store buffer drain, placed in front of the data cache's upstream port inside the execute stage. It accepts one request per transaction and holds it stable on the cache port until `ufp_resp`. Loads win by default, and a starvation counter plus the buffer's urgent signal keep stores draining. Branch flushes squash an in-flight load's response without aborting the cache transaction.

## Interface
- `STARVE_LIMIT`, default 8: consecutive load grants allowed while a store is pending before a store is forced.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ld_req` in 1: load request valid.
- `ld_addr` in 32: load byte address.
- `ld_rmask` in 4: load byte read mask, nonzero.
- `ld_gnt` out 1: load accepted this cycle.
- `st_req` in 1: store-buffer drain request valid.
- `st_addr` in 32: store byte address.
- `st_wmask` in 4: store byte write mask, nonzero.
- `st_wdata` in 32: store data, lane-aligned.
- `st_urgent` in 1: store buffer full; store takes priority.
- `st_gnt` out 1: store accepted this cycle.
- `flush` in 1: branch mispredict flush.
- `ufp_addr` out 32, `ufp_rmask` out 4, `ufp_wmask` out 4, `ufp_wdata` out 32: cache request.
- `ufp_rdata` in 32, `ufp_resp` in 1: cache response.
- `ld_resp` out 1, `ld_rdata` out 32: load data return.
- `st_done` out 1: store written to the cache.
- `busy` out 1: transaction outstanding.

## Operation
- States:
  - IDLE: no request on the port.
  - LOAD: load outstanding.
  - STORE: store outstanding.
  - DRAIN: squashed load outstanding.
- At most one transaction is outstanding. Requests are accepted only in IDLE, and at most one grant is issued per cycle.
- Arbitration in IDLE:
  - A store wins if `st_req` and (`st_urgent` or `starve_cnt == STARVE_LIMIT` or !`ld_req`).
  - Otherwise a load wins if `ld_req` and !`flush`.
  - Otherwise no grant is issued.
- `ld_gnt` and `st_gnt` are combinational from IDLE and the inputs.
- A grant latches addr, masks and data into holding registers.
- Holding registers drive `ufp_*`:
  - `ufp_addr[1:0]` is forced to 0.
  - A load drives `ufp_wmask = 0`. A store drives `ufp_rmask = 0`.
  - In IDLE, `ufp_*` is all zero.
- Transitions:
  - IDLE -> LOAD on `ld_gnt`; IDLE -> STORE on `st_gnt`.
  - LOAD -> IDLE on `ufp_resp` with !`flush`.
  - LOAD -> DRAIN on `flush` with !`ufp_resp`.
  - LOAD -> IDLE on `flush` and `ufp_resp` together; `ld_resp` is suppressed.
  - DRAIN -> IDLE on `ufp_resp`; `ld_resp` is never asserted in DRAIN.
  - STORE -> IDLE on `ufp_resp`. `flush` is ignored because stores are committed.
- Outputs during a transaction:
  - `ld_resp = (state==LOAD) & ufp_resp & !flush`.
  - `ld_rdata = ufp_rdata` when `ld_resp`, else 0.
  - `st_done = (state==STORE) & ufp_resp`.
- Starvation counter (`starve_cnt`, width `$clog2(STARVE_LIMIT+1)`):
  - Increments on `ld_gnt` while `st_req` is high, saturating at `STARVE_LIMIT`.
  - Clears on `st_gnt` or when `st_req` is low.
- `busy = (state != IDLE)`.
- A `flush` in IDLE blocks only a load grant; a store may still be granted that cycle.

## Timing
- Reset values: state IDLE, `starve_cnt` 0, and all outputs 0 (`ld_gnt`, `st_gnt`, `ufp_*`, `ld_resp`, `ld_rdata`, `st_done`, `busy`).
- Reset mid-transaction: return to IDLE at the next edge and drop the request. No `ld_resp` or `st_done` is produced for it. Any late `ufp_resp` seen in IDLE is ignored.
- Grant in cycle N puts the request on `ufp_*` in cycle N+1. `ufp_*` holds stable until the cycle in which `ufp_resp` is seen (cycle M ≥ N+1).
- `ld_resp` and `st_done` assert in cycle M, combinationally.
- IDLE is reached at M+1, where the next grant is possible. Minimum spacing between grants is 2 cycles.
- `ufp_resp` outside LOAD, STORE and DRAIN is ignored.
- Simultaneous `ld_req` and `st_req` with no urgency and the counter below the limit: the load wins and the store waits.

## Test plan
- Load at `ld_addr` 0x1003, `ld_rmask` 4'b1000; cache responds 3 cycles after the request appears with `ufp_rdata` 0xAABBCCDD -> `ufp_addr` 0x1000 for 3 cycles, then `ld_resp`=1 with `ld_rdata` 0xAABBCCDD, then `busy`=0.
- `ld_req` and `st_req` both held high, `STARVE_LIMIT`=8, cache responds in 1 cycle -> 8 load grants, then 1 store grant, `starve_cnt` returns to 0, and the pattern repeats.
- `st_urgent`=1 with `ld_req` in the same cycle -> `st_gnt`=1, `ld_gnt`=0, and `st_done` pulses on `ufp_resp`.
- `flush` 1 cycle after a load grant, `ufp_resp` 4 cycles later -> state DRAIN, `ufp_*` held, `ld_resp` never asserts, IDLE the cycle after `ufp_resp`.
- `flush` during a store transaction -> the store completes and `st_done`=1. `flush` in IDLE with only `ld_req` -> `ld_gnt`=0.
- Assert `rst` during LOAD, then `ufp_resp` 1 cycle later -> all outputs 0, no `ld_resp`, and a grant is possible in the first cycle after reset deasserts.
